// File: rtl/fp_addsub_pkg.sv
// Shared definitions for the FPU add/sub datapath: FSM encoding and guard/round/sticky layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fp_addsub_pkg;

    typedef enum logic [3:0] {
        ST_GET_A,
        ST_GET_B,
        ST_UNPACK,
        ST_SPECIAL,
        ST_ALIGN,
        ST_ADD,
        ST_NORM,
        ST_ROUND,
        ST_PUT_Z
    } state_t;

    // Working mantissa keeps three extra bits below the stored LSB: {.., G, R, S}
    localparam int S_IDX = 0;
    localparam int R_IDX = 1;
    localparam int G_IDX = 2;
    localparam int GRS_W = 3;

endpackage

// File: rtl/fp_lzc.sv
// Leading-zero counter; returns WIDTH when the input is all zeros.
// Latency: combinational.
// Backpressure: none.
module fp_lzc #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] din,
    output logic [CNT_W-1:0] cnt
);

    // Scan upward so the highest set bit is the last (winning) assignment
    always_comb begin
        cnt = CNT_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (din[i]) cnt = CNT_W'(WIDTH - 1 - i);
        end
    end

endmodule

// File: rtl/fp_addsub.sv
// IEEE-754 add/subtract, RNE rounding, NaN/inf/zero handling; FP_ADDSUB_FTZ_EN selects flush-to-zero.
// Latency: output_z_stb rises 6 cycles after the B capture edge (2 cycles for special operands).
// Backpressure: one op in flight; no operand acked while busy; result held until output_z_ack.
module fp_addsub
    import fp_addsub_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [EXP_W+MAN_W:0]     input_a,
    input  logic                     input_a_stb,
    output logic                     input_a_ack,
    input  logic [EXP_W+MAN_W:0]     input_b,
    input  logic                     input_op,
    input  logic                     input_b_stb,
    output logic                     input_b_ack,
    output logic [EXP_W+MAN_W:0]     output_z,
    output logic                     output_z_stb,
    input  logic                     output_z_ack
);

    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int MW    = MAN_W + 1 + GRS_W;      // hidden + stored + G,R,S
    localparam int EW    = EXP_W + 2;              // signed unbiased exponent
    localparam int CW    = $clog2(MW + 1);
    localparam int BIAS  = (2 ** (EXP_W - 1)) - 1;
    localparam int E_MIN = 1 - BIAS;
    localparam int E_OVF = BIAS + 1;               // biased all-ones
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    state_t                state_q, state_d;
    logic                  a_ack_q, a_ack_d, b_ack_q, b_ack_d, z_stb_q, z_stb_d;
    logic [W-1:0]          a_q, a_d, b_q, b_d, z_q, z_d;
    logic                  op_q, op_d;
    logic                  a_s_q, a_s_d, b_s_q, b_s_d, z_s_q, z_s_d;
    logic                  a_nan_q, a_nan_d, b_nan_q, b_nan_d;
    logic                  a_inf_q, a_inf_d, b_inf_q, b_inf_d;
    logic                  a_zero_q, a_zero_d, b_zero_q, b_zero_d;
    logic signed [EW-1:0]  a_e_q, a_e_d, b_e_q, b_e_d, z_e_q, z_e_d;
    logic [MW-1:0]         a_m_q, a_m_d, b_m_q, b_m_d;
    logic [MW:0]           z_m_q, z_m_d;

    logic [EXP_W-1:0]      a_exp, b_exp;
    logic [MAN_W-1:0]      a_man, b_man;
    logic [CW-1:0]         lz;
    logic [EW-1:0]         sh_amt, nshift;
    logic [MAN_W+1:0]      mr;
    logic signed [EW-1:0]  re;
    logic                  round_up;
`ifndef FP_ADDSUB_FTZ_EN
    logic signed [EW-1:0]  headroom;
`endif

    assign a_exp = a_q[W-2:MAN_W];
    assign a_man = a_q[MAN_W-1:0];
    assign b_exp = b_q[W-2:MAN_W];
    assign b_man = b_q[MAN_W-1:0];

    assign input_a_ack  = a_ack_q;
    assign input_b_ack  = b_ack_q;
    assign output_z     = z_q;
    assign output_z_stb = z_stb_q;

    fp_lzc #(.WIDTH(MW), .CNT_W(CW)) u_lzc (
        .din (z_m_q[MW-1:0]),
        .cnt (lz)
    );

    // Right shift that ORs every bit pushed past the bottom into the sticky position
    function automatic logic [MW-1:0] shift_sticky(input logic [MW-1:0] m, input logic [EW-1:0] d);
        logic [MW-1:0] r;
        logic [MW-1:0] lost_mask;
        lost_mask = ~({MW{1'b1}} << d);
        r = m >> d;
        r[S_IDX] = r[S_IDX] | (|(m & lost_mask));
        return r;
    endfunction

    // Next-state, handshake and per-stage datapath
    always_comb begin
        state_d  = state_q;
        a_ack_d  = a_ack_q;  b_ack_d  = b_ack_q;  z_stb_d = z_stb_q;
        a_d      = a_q;      b_d      = b_q;      z_d     = z_q;     op_d = op_q;
        a_s_d    = a_s_q;    b_s_d    = b_s_q;    z_s_d   = z_s_q;
        a_nan_d  = a_nan_q;  b_nan_d  = b_nan_q;  a_inf_d = a_inf_q; b_inf_d = b_inf_q;
        a_zero_d = a_zero_q; b_zero_d = b_zero_q;
        a_e_d    = a_e_q;    b_e_d    = b_e_q;    z_e_d   = z_e_q;
        a_m_d    = a_m_q;    b_m_d    = b_m_q;    z_m_d   = z_m_q;
        sh_amt   = '0;       nshift   = '0;       mr      = '0;
        re       = '0;       round_up = 1'b0;
`ifndef FP_ADDSUB_FTZ_EN
        headroom = '0;
`endif
        case (state_q)
            ST_GET_A: begin
                if (a_ack_q && input_a_stb) begin
                    a_d     = input_a;
                    a_ack_d = 1'b0;
                    state_d = ST_GET_B;
                end else begin
                    a_ack_d = 1'b1;
                end
            end
            ST_GET_B: begin
                if (b_ack_q && input_b_stb) begin
                    b_d     = input_b;
                    op_d    = input_op;
                    b_ack_d = 1'b0;
                    state_d = ST_UNPACK;
                end else begin
                    b_ack_d = 1'b1;
                end
            end
            ST_UNPACK: begin
                a_s_d   = a_q[W-1];
                b_s_d   = b_q[W-1] ^ op_q;
                a_nan_d = (&a_exp) && (|a_man);
                b_nan_d = (&b_exp) && (|b_man);
                a_inf_d = (&a_exp) && !(|a_man);
                b_inf_d = (&b_exp) && !(|b_man);
                a_e_d   = (a_exp == '0) ? EW'(E_MIN) : $signed({2'b00, a_exp}) - EW'(BIAS);
                b_e_d   = (b_exp == '0) ? EW'(E_MIN) : $signed({2'b00, b_exp}) - EW'(BIAS);
`ifdef FP_ADDSUB_FTZ_EN
                a_zero_d = (a_exp == '0);
                b_zero_d = (b_exp == '0);
                a_m_d    = (a_exp == '0) ? '0 : {1'b1, a_man, {GRS_W{1'b0}}};
                b_m_d    = (b_exp == '0) ? '0 : {1'b1, b_man, {GRS_W{1'b0}}};
`else
                a_zero_d = (a_exp == '0) && (a_man == '0);
                b_zero_d = (b_exp == '0) && (b_man == '0);
                a_m_d    = {(a_exp != '0), a_man, {GRS_W{1'b0}}};
                b_m_d    = {(b_exp != '0), b_man, {GRS_W{1'b0}}};
`endif
                state_d = ST_SPECIAL;
            end
            ST_SPECIAL: begin
                state_d = ST_PUT_Z;
                z_stb_d = 1'b1;
                if (a_nan_q || b_nan_q || (a_inf_q && b_inf_q && (a_s_q != b_s_q))) begin
                    z_d = QNAN;
                end else if (a_inf_q) begin
                    z_d = {a_s_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                end else if (b_inf_q) begin
                    z_d = {b_s_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                end else if (a_zero_q && b_zero_q) begin
                    z_d = {a_s_q & b_s_q, {(W-1){1'b0}}};
                end else begin
                    state_d = ST_ALIGN;
                    z_stb_d = 1'b0;
                end
            end
            ST_ALIGN: begin
                if (a_e_q > b_e_q) begin
                    sh_amt = $unsigned(a_e_q - b_e_q);
                    b_m_d  = shift_sticky(b_m_q, sh_amt);
                    z_e_d  = a_e_q;
                end else begin
                    sh_amt = $unsigned(b_e_q - a_e_q);
                    a_m_d  = shift_sticky(a_m_q, sh_amt);
                    z_e_d  = b_e_q;
                end
                state_d = ST_ADD;
            end
            ST_ADD: begin
                if (a_s_q == b_s_q) begin
                    z_m_d = {1'b0, a_m_q} + {1'b0, b_m_q};
                    z_s_d = a_s_q;
                end else if (a_m_q >= b_m_q) begin
                    z_m_d = {1'b0, a_m_q} - {1'b0, b_m_q};
                    z_s_d = a_s_q;
                end else begin
                    z_m_d = {1'b0, b_m_q} - {1'b0, a_m_q};
                    z_s_d = b_s_q;
                end
                // Exact cancellation always yields +0
                if (z_m_d == '0) z_s_d = 1'b0;
                state_d = ST_NORM;
            end
            ST_NORM: begin
                if (z_m_q[MW]) begin
                    z_m_d = {1'b0, z_m_q[MW:2], |z_m_q[1:0]};
                    z_e_d = z_e_q + EW'(1);
                end else begin
                    nshift = EW'(lz);
`ifndef FP_ADDSUB_FTZ_EN
                    // Stop at the minimum exponent so small results stay denormal
                    headroom = z_e_q - EW'(E_MIN);
                    if ($signed(nshift) > headroom) nshift = $unsigned(headroom);
`endif
                    z_m_d = z_m_q << nshift;
                    z_e_d = z_e_q - $signed(nshift);
                end
                state_d = ST_ROUND;
            end
            ST_ROUND: begin
                round_up = z_m_q[G_IDX] & (z_m_q[R_IDX] | z_m_q[S_IDX] | z_m_q[GRS_W]);
                mr = {1'b0, z_m_q[MW-1:GRS_W]} + (MAN_W+2)'(round_up);
                re = z_e_q;
                if (mr[MAN_W+1]) begin
                    mr = mr >> 1;
                    re = re + EW'(1);
                end
                if (re >= EW'(E_OVF)) begin
                    z_d = {z_s_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
`ifdef FP_ADDSUB_FTZ_EN
                end else if (!mr[MAN_W] || (re < EW'(E_MIN))) begin
                    z_d = {z_s_q, {(W-1){1'b0}}};
`else
                end else if (!mr[MAN_W]) begin
                    z_d = {z_s_q, {EXP_W{1'b0}}, mr[MAN_W-1:0]};
`endif
                end else begin
                    z_d = {z_s_q, EXP_W'(re + EW'(BIAS)), mr[MAN_W-1:0]};
                end
                z_stb_d = 1'b1;
                state_d = ST_PUT_Z;
            end
            ST_PUT_Z: begin
                if (z_stb_q && output_z_ack) begin
                    z_stb_d = 1'b0;
                    state_d = ST_GET_A;
                end
            end
            default: state_d = ST_GET_A;
        endcase
    end

    // State and datapath registers; reset aborts any op in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_GET_A;
            a_ack_q <= 1'b0;  b_ack_q <= 1'b0;  z_stb_q <= 1'b0;
            a_q     <= '0;    b_q     <= '0;    z_q     <= '0;    op_q <= 1'b0;
            a_s_q   <= 1'b0;  b_s_q   <= 1'b0;  z_s_q   <= 1'b0;
            a_nan_q <= 1'b0;  b_nan_q <= 1'b0;  a_inf_q <= 1'b0;  b_inf_q <= 1'b0;
            a_zero_q <= 1'b0; b_zero_q <= 1'b0;
            a_e_q   <= '0;    b_e_q   <= '0;    z_e_q   <= '0;
            a_m_q   <= '0;    b_m_q   <= '0;    z_m_q   <= '0;
        end else begin
            state_q <= state_d;
            a_ack_q <= a_ack_d;  b_ack_q <= b_ack_d;  z_stb_q <= z_stb_d;
            a_q     <= a_d;      b_q     <= b_d;      z_q     <= z_d;     op_q <= op_d;
            a_s_q   <= a_s_d;    b_s_q   <= b_s_d;    z_s_q   <= z_s_d;
            a_nan_q <= a_nan_d;  b_nan_q <= b_nan_d;  a_inf_q <= a_inf_d; b_inf_q <= b_inf_d;
            a_zero_q <= a_zero_d; b_zero_q <= b_zero_d;
            a_e_q   <= a_e_d;    b_e_q   <= b_e_d;    z_e_q   <= z_e_d;
            a_m_q   <= a_m_d;    b_m_q   <= b_m_d;    z_m_q   <= z_m_d;
        end
    end

endmodule
